// File: rtl/ssd1306_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ssd1306_spi_tx_if
// Description : Byte command handshake between an OLED command/data producer
//               (master) and the SSD1306 SPI byte transmitter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ssd1306_spi_tx_if;
  logic       command_start;
  logic [7:0] command_in;
  logic       command_last_byte;
  logic       command_ready;

  modport master (
    output command_start,
    output command_in,
    output command_last_byte,
    input  command_ready
  );

  modport slave (
    input  command_start,
    input  command_in,
    input  command_last_byte,
    output command_ready
  );
endinterface
`default_nettype wire

// File: rtl/ssd1306_spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : ssd1306_spi_tx
// Description : SPI mode-0 byte transmitter for the SSD1306 serial port.
//               Accepts one byte per handshake, shifts it out MSB first and
//               frames CS# per byte using a latched last-byte flag.
//               Build option SSD1306_SPI_TX_BURST_EN: when defined, CS# stays
//               low between bytes until a byte flagged last; when undefined,
//               every byte is treated as last (CS# released after each byte).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd1306_spi_tx #(
  parameter int CLK_DIV = 2  // clk_in cycles per SCLK half-period, 1..255
) (
  input  wire logic       clk_in,
  input  wire logic       resetn_in,
  ssd1306_spi_tx_if.slave cmd,
  output logic            oled_sclk,
  output logic            oled_mosi,
  output logic            oled_csn
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_HIGH   = 3'd2,
    S_LOW    = 3'd3,
    S_TRAIL  = 3'd4,
    S_CS_GAP = 3'd5
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [6:0] shift_q, shift_d;   // remaining bits; bit7 goes straight to MOSI
  logic       last_q, last_d;
  logic       ready_q, ready_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       csn_q, csn_d;

  logic       phase_done;
  logic       accept;
  logic       last_in;

`ifdef SSD1306_SPI_TX_BURST_EN
  assign last_in = cmd.command_last_byte;
`else
  // Without burst support every byte closes its own CS# frame.
  logic unused_last_byte;
  assign unused_last_byte = cmd.command_last_byte;
  assign last_in          = 1'b1;
`endif

  assign phase_done = (phase_q == PHASE_LAST);
  assign accept     = cmd.command_start & ready_q;

  // Next-state and registered-output logic for the transmit sequencer.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_done ? 8'd0 : phase_q + 8'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    last_d    = last_q;
    ready_d   = ready_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    csn_d     = csn_q;

    case (state_q)
      S_IDLE: begin
        // ready rises one edge after reset release; CS# keeps burst state
        phase_d   = 8'd0;
        bit_idx_d = 3'd0;
        ready_d   = 1'b1;
        sclk_d    = 1'b0;
        mosi_d    = 1'b0;
        if (accept) begin
          shift_d = cmd.command_in[6:0];
          last_d  = last_in;
          ready_d = 1'b0;
          csn_d   = 1'b0;
          mosi_d  = cmd.command_in[7];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_done) begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_done) begin
          sclk_d = 1'b0;
          if (bit_idx_q != 3'd7) begin
            // Next bit changes on the falling edge, a full half-period
            // after the slave sampled the current one.
            bit_idx_d = bit_idx_q + 3'd1;
            mosi_d    = shift_q[6];
            shift_d   = {shift_q[5:0], 1'b0};
            state_d   = S_LOW;
          end else begin
            state_d = S_TRAIL;
          end
        end
      end
      S_LOW: begin
        if (phase_done) begin
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_TRAIL: begin
        // MOSI holds bit0 through TRAIL to give the last bit its hold time.
        if (phase_done) begin
          mosi_d = 1'b0;
          if (last_q) begin
            csn_d   = 1'b1;
            state_d = S_CS_GAP;
          end else begin
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_CS_GAP: begin
        if (phase_done) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      state_q   <= S_IDLE;
      phase_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 7'd0;
      last_q    <= 1'b1;
      ready_q   <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      csn_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      csn_q     <= csn_d;
    end
  end

  assign cmd.command_ready = ready_q;
  assign oled_sclk         = sclk_q;
  assign oled_mosi         = mosi_q;
  assign oled_csn          = csn_q;

endmodule
`default_nettype wire
